// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned level/strobe outputs of button_conditioner.
interface button_conditioner_if;
  logic u_raw;
  logic d_raw;
  logic u;
  logic d;
  logic u_pulse;
  logic d_pulse;

  modport master (
    output u_raw, d_raw,
    input  u, d, u_pulse, d_pulse
  );

  modport slave (
    input  u_raw, d_raw,
    output u, d, u_pulse, d_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Two independent synchronise-and-debounce channels (up, down) with press strobes.
// Build option: define BTN_ACTIVE_LOW_EN for pulled-up buttons (raw 0 = pressed).
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  typedef enum logic [1:0] {
    REL    = 2'd0,
    WAIT_P = 2'd1,
    PRESS  = 2'd2,
    WAIT_R = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 0 = up, channel 1 = down.
  logic [1:0] raw_in;
  logic [1:0] s1_q, s_q;
  logic [1:0] out_q, out_d;
  logic [1:0] pulse_q, pulse_d;
  state_t     state_q [2];
  state_t     state_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

`ifdef BTN_ACTIVE_LOW_EN
  // Invert ahead of the synchroniser so its reset value of 0 still means released.
  assign raw_in = ~{btn.d_raw, btn.u_raw};
`else
  assign raw_in = {btn.d_raw, btn.u_raw};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s_q  <= '0;
    end else begin
      s1_q <= raw_in;
      s_q  <= s1_q;
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = '0;
      pulse_d[ch] = 1'b0;
      case (state_q[ch])
        REL: begin
          if (s_q[ch]) state_d[ch] = WAIT_P;
        end
        WAIT_P: begin
          if (!s_q[ch]) begin
            state_d[ch] = REL;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = PRESS;
            pulse_d[ch] = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
        end
        PRESS: begin
          if (!s_q[ch]) state_d[ch] = WAIT_R;
        end
        WAIT_R: begin
          if (s_q[ch]) begin
            state_d[ch] = PRESS;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = REL;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
        end
        default: state_d[ch] = REL;
      endcase
      // Level output is registered alongside the state so it cannot glitch.
      out_d[ch] = (state_d[ch] == PRESS) || (state_d[ch] == WAIT_R);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        state_q[ch] <= REL;
        cnt_q[ch]   <= '0;
      end
      out_q   <= '0;
      pulse_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      out_q   <= out_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn.u       = out_q[0];
  assign btn.d       = out_q[1];
  assign btn.u_pulse = pulse_q[0];
  assign btn.d_pulse = pulse_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model queues expected outputs per edge.
module tb_button_conditioner;
  localparam int unsigned DB = 4;
  localparam int unsigned CW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_conditioner_if bif ();

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q [$];

  // Reference model: the level seen by the debouncer is the press value two edges old;
  // the output flips once DB+1 consecutive samples disagree with it.
  bit          h1 [2];
  bit          h2 [2];
  bit          mo [2];
  bit          mp [2];
  int unsigned run [2];

  function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_raw(input bit pu, input bit pd);
`ifdef BTN_ACTIVE_LOW_EN
    bif.u_raw = ~pu;
    bif.d_raw = ~pd;
`else
    bif.u_raw = pu;
    bif.d_raw = pd;
`endif
  endtask

  task automatic cycle(input bit pu, input bit pd, input bit rn);
    bit p [2];
    bit seen;
    @(negedge clk);
    rst_n = rn;
    set_raw(pu, pd);
    p[0] = pu;
    p[1] = pd;
    for (int ch = 0; ch < 2; ch++) begin
      if (!rn) begin
        h1[ch] = 0; h2[ch] = 0; mo[ch] = 0; mp[ch] = 0; run[ch] = 0;
      end else begin
        seen   = h2[ch];
        h2[ch] = h1[ch];
        h1[ch] = p[ch];
        mp[ch] = 0;
        if (seen != mo[ch]) begin
          run[ch]++;
          if (run[ch] == DB + 1) begin
            mo[ch]  = seen;
            mp[ch]  = seen;
            run[ch] = 0;
          end
        end else begin
          run[ch] = 0;
        end
      end
    end
    exp_q.push_back({mo[0], mo[1], mp[0], mp[1]});
  endtask

  // Monitor: one expected entry per rising edge once stimulus is running.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (rst_n) begin
          n_vec++;
          n_err++;
          $display("FAIL queue_underflow: got empty expected-queue required one entry at %0t", $time);
        end
      end else begin
        check("outputs{u,d,up,dp}", {bif.u, bif.d, bif.u_pulse, bif.d_pulse}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int unsigned hold [2];
    bit          lvl  [2];
    bit          rn;
    set_raw(0, 0);
    rst_n = 1'b0;

    // Reset held with both buttons pressed, then release: outputs rise on edge 7.
    repeat (3) cycle(1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 1, 1);
      @(posedge clk); #2;
      check("reset_release_u", {3'b0, bif.u}, {3'b0, (k >= 7)});
    end
    repeat (10) cycle(0, 0, 1);

    // Clean up press.
    for (int k = 1; k <= 9; k++) begin
      cycle(1, 0, 1);
      @(posedge clk); #2;
      check("press_u_up", {2'b0, bif.u, bif.u_pulse},
            {2'b0, (k >= 7), (k == 7)});
    end

    // Bounce on down while up stays pressed.
    begin
      bit bseq [5] = '{1, 0, 1, 1, 0};
      for (int i = 0; i < 5; i++) cycle(1, bseq[i], 1);
    end
    repeat (10) cycle(1, 1, 1);

    // Up: 3-cycle glitch, then sustained release.
    repeat (3) cycle(0, 1, 1);
    repeat (6) cycle(1, 1, 1);
    repeat (10) cycle(0, 1, 1);
    repeat (10) cycle(0, 0, 1);

    // Simultaneous press, then reset during WAIT_R.
    repeat (9) cycle(1, 1, 1);
    repeat (4) cycle(0, 0, 1);
    cycle(0, 0, 0);
    #1;
    check("async_reset", {bif.u, bif.d, bif.u_pulse, bif.d_pulse}, 4'b0000);
    repeat (2) cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 1);

    // Randomised holds per channel with occasional resets.
    hold[0] = 0; hold[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          lvl[ch]  = $urandom_range(1, 0) == 1;
          hold[ch] = $urandom_range(8, 1);
        end
        hold[ch]--;
      end
      rn = ($urandom_range(150, 0) != 0);
      cycle(lvl[0], lvl[1], rn);
    end
    repeat (12) cycle(0, 0, 1);

    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
